// File: rtl/multicycle_control.sv
// Main control unit for the multicycle MIPS datapath.
// Moore FSM: state register, next-state logic and output decode are separate
// processes. Outputs are combinational from the current state, plus funct,
// zero and mem_ready in the states that use them.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUCnt,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  state_t cur, nxt;

  assign state = cur;

  // R-type funct decode: returns {legal, alu_code}; unknown funct -> ADD, not legal.
  function automatic logic [4:0] decode_funct(input logic [5:0] f);
    logic [4:0] r;
    case (f)
      6'h20, 6'h21: r = {1'b1, ALU_ADD};
      6'h22, 6'h23: r = {1'b1, ALU_SUB};
      6'h24:        r = {1'b1, ALU_AND};
      6'h25:        r = {1'b1, ALU_OR};
      6'h27:        r = {1'b1, ALU_NOR};
      6'h2A:        r = {1'b1, ALU_SLT};
      6'h00:        r = {1'b1, ALU_SLL};
      6'h02:        r = {1'b1, ALU_SRL};
      default:      r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

  logic [4:0] fdec;
  assign fdec = decode_funct(funct);

  // State register; reset drops straight back to FETCH, aborting any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // Next-state selection.
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BEQ;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = fdec[4] ? S_RWB : S_FETCH;
      S_RWB:    nxt = S_FETCH;
      S_BEQ:    nxt = S_FETCH;
      S_ADDIEX: nxt = S_ADDIWB;
      S_ADDIWB: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // Output decode; while reset is held all enables and the illegal flag are masked.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    ALUCnt   = ALU_AND;
    illegal  = 1'b0;
    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUCnt  = ALU_ADD;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUCnt  = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
          default:                                       illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCnt  = ALU_ADD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUCnt  = fdec[3:0];
        illegal = ~fdec[4];
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        ALUCnt   = fdec[3:0];
      end
      S_BEQ: begin
        ALUSrcA = 1'b1;
        ALUCnt  = ALU_SUB;
        PCSrc   = 2'b01;
        PCWrite = zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCnt  = ALU_ADD;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle pushes the
// hand-written expected output vector, a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUCnt;
  logic       illegal;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUCnt(ALUCnt), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [3:0] alu;
    logic       ill;
  } exp_t;

  exp_t  expq[$];
  string nameq[$];
  int    nvec = 0;
  int    nmis = 0;

  // Field order: state, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
  // RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUCnt, illegal.
  function automatic exp_t ex(int st, int pcw, int iord, int mrd, int mwr, int irw,
                              int m2r, int rdst, int rw, int asa, int asb, int pcs,
                              int alu, int ill);
    exp_t e;
    e.st = st[3:0]; e.pcw = pcw[0]; e.iord = iord[0]; e.mrd = mrd[0]; e.mwr = mwr[0];
    e.irw = irw[0]; e.m2r = m2r[0]; e.rdst = rdst[0]; e.rw = rw[0]; e.asa = asa[0];
    e.asb = asb[1:0]; e.pcs = pcs[1:0]; e.alu = alu[3:0]; e.ill = ill[0];
    return e;
  endfunction

  exp_t RST, F1, F0, DEC, DECILL;

  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic m, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n = r; opcode = op; funct = fn; zero = z; mem_ready = m;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  // Monitor: compare the DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t  w, g;
      string nm;
      w  = expq.pop_front();
      nm = nameq.pop_front();
      g  = {state, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUCnt, illegal};
      nvec++;
      if (g !== w) begin
        nmis++;
        $display("FAIL %s: got st=%0d ctl=%b asb=%b pcs=%b alu=%0d ill=%b, want st=%0d ctl=%b asb=%b pcs=%b alu=%0d ill=%b",
                 nm, g.st, {g.pcw, g.iord, g.mrd, g.mwr, g.irw, g.m2r, g.rdst, g.rw, g.asa},
                 g.asb, g.pcs, g.alu, g.ill, w.st,
                 {w.pcw, w.iord, w.mrd, w.mwr, w.irw, w.m2r, w.rdst, w.rw, w.asa},
                 w.asb, w.pcs, w.alu, w.ill);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    RST    = ex(0, 0,0,0,0,0,0,0,0,0, 1,0,2,0);
    F1     = ex(0, 1,0,1,0,1,0,0,0,0, 1,0,2,0);
    F0     = ex(0, 0,0,1,0,0,0,0,0,0, 1,0,2,0);
    DEC    = ex(1, 0,0,0,0,0,0,0,0,0, 3,0,2,0);
    DECILL = ex(1, 0,0,0,0,0,0,0,0,0, 3,0,2,1);

    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;

    // reset held: FETCH muxes, every enable low
    step(0, 6'h00, 6'h00, 0, 1, RST, "reset0");
    step(0, 6'h00, 6'h00, 0, 1, RST, "reset1");

    // R-type sub
    step(1, 6'h00, 6'h22, 0, 1, F1,  "sub_fetch");
    step(1, 6'h00, 6'h22, 0, 1, DEC, "sub_decode");
    step(1, 6'h00, 6'h22, 0, 1, ex(6, 0,0,0,0,0,0,0,0,1, 0,0,3,0), "sub_exec");
    step(1, 6'h00, 6'h22, 0, 1, ex(7, 0,0,0,0,0,0,1,1,0, 0,0,3,0), "sub_rwb");

    // lw with two stall cycles in MEMRD
    step(1, 6'h23, 6'h00, 0, 1, F1,  "lw_fetch");
    step(1, 6'h23, 6'h00, 0, 1, DEC, "lw_decode");
    step(1, 6'h23, 6'h00, 0, 1, ex(2, 0,0,0,0,0,0,0,0,1, 2,0,2,0), "lw_memadr");
    step(1, 6'h23, 6'h00, 0, 0, ex(3, 0,1,1,0,0,0,0,0,0, 0,0,0,0), "lw_memrd_stall0");
    step(1, 6'h23, 6'h00, 0, 0, ex(3, 0,1,1,0,0,0,0,0,0, 0,0,0,0), "lw_memrd_stall1");
    step(1, 6'h23, 6'h00, 0, 1, ex(3, 0,1,1,0,0,0,0,0,0, 0,0,0,0), "lw_memrd_ready");
    step(1, 6'h23, 6'h00, 0, 1, ex(4, 0,0,0,0,0,1,0,1,0, 0,0,0,0), "lw_memwb");

    // beq taken, with one FETCH stall first
    step(1, 6'h04, 6'h00, 1, 0, F0,  "beq1_fetch_stall");
    step(1, 6'h04, 6'h00, 1, 1, F1,  "beq1_fetch");
    step(1, 6'h04, 6'h00, 1, 1, DEC, "beq1_decode");
    step(1, 6'h04, 6'h00, 1, 1, ex(8, 1,0,0,0,0,0,0,0,1, 0,1,3,0), "beq_taken");

    // beq not taken
    step(1, 6'h04, 6'h00, 0, 1, F1,  "beq0_fetch");
    step(1, 6'h04, 6'h00, 0, 1, DEC, "beq0_decode");
    step(1, 6'h04, 6'h00, 0, 1, ex(8, 0,0,0,0,0,0,0,0,1, 0,1,3,0), "beq_not_taken");

    // illegal opcode
    step(1, 6'h3F, 6'h00, 0, 1, F1,     "illop_fetch");
    step(1, 6'h3F, 6'h00, 0, 1, DECILL, "illop_decode");

    // jump
    step(1, 6'h02, 6'h00, 0, 1, F1,  "j_fetch");
    step(1, 6'h02, 6'h00, 0, 1, DEC, "j_decode");
    step(1, 6'h02, 6'h00, 0, 1, ex(11, 1,0,0,0,0,0,0,0,0, 0,2,0,0), "j_jump");

    // sll
    step(1, 6'h00, 6'h00, 0, 1, F1,  "sll_fetch");
    step(1, 6'h00, 6'h00, 0, 1, DEC, "sll_decode");
    step(1, 6'h00, 6'h00, 0, 1, ex(6, 0,0,0,0,0,0,0,0,1, 0,0,6,0), "sll_exec");
    step(1, 6'h00, 6'h00, 0, 1, ex(7, 0,0,0,0,0,0,1,1,0, 0,0,6,0), "sll_rwb");

    // illegal funct
    step(1, 6'h00, 6'h3F, 0, 1, F1,  "illfn_fetch");
    step(1, 6'h00, 6'h3F, 0, 1, DEC, "illfn_decode");
    step(1, 6'h00, 6'h3F, 0, 1, ex(6, 0,0,0,0,0,0,0,0,1, 0,0,2,1), "illfn_exec");

    // addi
    step(1, 6'h08, 6'h00, 0, 1, F1,  "addi_fetch");
    step(1, 6'h08, 6'h00, 0, 1, DEC, "addi_decode");
    step(1, 6'h08, 6'h00, 0, 1, ex(9,  0,0,0,0,0,0,0,0,1, 2,0,2,0), "addi_ex");
    step(1, 6'h08, 6'h00, 0, 1, ex(10, 0,0,0,0,0,0,0,1,0, 0,0,0,0), "addi_wb");

    // sw, stalled in MEMWR, then aborted by reset
    step(1, 6'h2B, 6'h00, 0, 1, F1,  "sw_fetch");
    step(1, 6'h2B, 6'h00, 0, 1, DEC, "sw_decode");
    step(1, 6'h2B, 6'h00, 0, 1, ex(2, 0,0,0,0,0,0,0,0,1, 2,0,2,0), "sw_memadr");
    step(1, 6'h2B, 6'h00, 0, 0, ex(5, 0,1,0,1,0,0,0,0,0, 0,0,0,0), "sw_memwr_stall");
    step(0, 6'h2B, 6'h00, 0, 0, RST, "sw_reset_abort");
    step(1, 6'h2B, 6'h00, 0, 1, F1,  "post_reset_fetch");
    step(1, 6'h2B, 6'h00, 0, 1, DEC, "post_reset_decode");

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit of the multicycle MIPS datapath, sitting directly upstream of the ALU. A Moore state machine that sequences each instruction through fetch/decode/execute/memory/writeback. It drives every datapath mux and write enable, plus the 4-bit ALU operation code (`ALUCnt`), which it decodes from opcode and funct. It stalls on a memory-ready handshake and uses the ALU `zero` flag to resolve `beq`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]; valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag (combinational, same cycle)
- `mem_ready`  in  1  memory completes access this cycle
- `PCWrite`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath controls
- `ALUSrcB`  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
- `PCSrc`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `ALUCnt`  out  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 SLL, 7 SRL
- `illegal`  out  1  one-cycle pulse on unsupported opcode/funct
- `state`  out  4  current state encoding (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH.
- All outputs are 0 unless listed for the current state.
- FETCH: MemRead=1, ALUSrcB=01, ALUCnt=ADD, PCSrc=00; IRWrite=PCWrite=mem_ready. Stay until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcB=11, ALUCnt=ADD. Next state by opcode: 0x23/0x2B→MEMADR, 0x00→EXEC, 0x04→BEQ, 0x08→ADDIEX, 0x02→JUMP. Any other opcode → FETCH with illegal=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
- MEMWR: IorD=1, MemWrite=1. Holds until mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. funct decode: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL → RWB. Any other funct: ALUCnt=ADD, illegal=1, next state FETCH (no writeback).
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, ALUCnt keeps its EXEC value → FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCWrite=zero → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD → ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.
- JUMP: PCSrc=10, PCWrite=1 → FETCH.

## Timing
- Only the state register is sequential. All outputs are combinational from state, plus funct (EXEC/RWB), zero (BEQ) and mem_ready (FETCH/MEMRD/MEMWR). No glitch requirement beyond a single clock domain.
- rst_n low: state=FETCH immediately (asynchronous). All write/read enables are forced 0: PCWrite, IRWrite, MemRead, MemWrite, RegWrite. Muxes show FETCH values, illegal=0.
- rst_n release: first FETCH begins at the next rising edge. Reset asserted mid-instruction aborts it with no further writes.
- Latency with mem_ready tied 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2, illegal funct 3.
- Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle. MemRead/MemWrite stay asserted and the address stays stable (IorD held).
- `illegal` is high for exactly the one cycle it is decoded in.

## Test plan
- Reset mid-MEMWR (sw, mem_ready=0) → state=0 and MemWrite=0 at once; after release, FETCH with MemRead=1.
- R-type funct 0x22, mem_ready=1 → states 0,1,6,7,0; ALUCnt=3 in EXEC and RWB; RegWrite=1, RegDst=1 only in RWB.
- lw with mem_ready low 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; IorD=1 for all three MEMRD cycles; RegWrite=1 with MemtoReg=1 in MEMWB.
- beq with zero=1, then again with zero=0 → BEQ shows PCWrite=1 then 0; PCSrc=01, ALUCnt=3 in both.
- opcode 0x3F → states 0,1,0; illegal=1 only in DECODE; no write enable asserted.
- j opcode 0x02 → JUMP: PCWrite=1, PCSrc=10. funct 0x00 in EXEC → ALUCnt=6; funct 0x3F → illegal pulse, then back to FETCH.
